// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - opcode, operand-select and FSM encodings shared by the execute stage
package exe_stage_pkg;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_AND = 6'd3,
        OP_OR  = 6'd4,
        OP_XOR = 6'd5,
        OP_SLT = 6'd6,
        OP_SLL = 6'd7,
        OP_SRL = 6'd8,
        OP_MUL = 6'd9
    } op_e;

    typedef enum logic [1:0] {
        SRC_REG  = 2'b00,
        SRC_SEXT = 2'b01,
        SRC_ZEXT = 2'b10,
        SRC_RSVD = 2'b11
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Single-cycle opcodes that commit a register write; MUL is handled by the FSM.
    function automatic logic op_writes(input logic [5:0] op);
        return (op != 6'd0) && (op < 6'd9);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE inputs and EXE/MEM outputs of the execute stage
interface exe_stage_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
);
    logic [DSIZE-1:0] a_in;
    logic [DSIZE-1:0] b_in;
    logic [5:0]       op_in;
    logic [1:0]       src_in;
    logic [31:0]      signext_in;
    logic [ASIZE-1:0] waddr_in;
    logic [DSIZE-1:0] alu_out;
    logic [ASIZE-1:0] waddr_out;
    logic             wen_out;
    logic             stall;

    modport master (
        output a_in, b_in, op_in, src_in, signext_in, waddr_in,
        input  alu_out, waddr_out, wen_out, stall
    );

    modport slave (
        input  a_in, b_in, op_in, src_in, signext_in, waddr_in,
        output alu_out, waddr_out, wen_out, stall
    );
endinterface

// File: rtl/exe_stage_mul_iter.sv
// rtl/exe_stage_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module exe_stage_mul_iter #(
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic             done,
    output logic [DSIZE-1:0] product
);
    localparam int CW = $clog2(DSIZE);

    logic             active_q, active_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0] acc_q, acc_d;
    logic [DSIZE-1:0] mcand_q, mcand_d;
    logic [DSIZE-1:0] mplier_q, mplier_d;

    // Load operands on start, then add/shift once per cycle; product is the post-step accumulator
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = active_q && (cnt_q == CW'(DSIZE - 1));
        if (active_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end
        end else if (start) begin
            active_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end
        product = acc_d;
    end

    // Iteration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand select, ALU, MUL sequencing and EXE/MEM register
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
) (
    input  logic           clk,
    input  logic           rst,
    exe_stage_if.slave     bus
);
    state_e           state_q, state_d;
    logic [DSIZE-1:0] alu_q, alu_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic             wen_q, wen_d;
    logic [ASIZE-1:0] waddr_cap_q, waddr_cap_d;

    logic [DSIZE-1:0] b_sel;
    logic [DSIZE-1:0] result;
    logic             stall_c;
    logic             mul_start;
    logic             mul_done;
    logic [DSIZE-1:0] mul_product;

    // Operand-B select; the reserved encoding falls back to the register value
    always_comb begin
        b_sel = bus.b_in;
        case (bus.src_in)
            SRC_SEXT: b_sel = bus.signext_in[DSIZE-1:0];
            SRC_ZEXT: b_sel = {{(DSIZE-16){1'b0}}, bus.signext_in[15:0]};
            default:  b_sel = bus.b_in;
        endcase
    end

    // Single-cycle ALU result
    always_comb begin
        result = '0;
        case (bus.op_in)
            OP_ADD:  result = bus.a_in + b_sel;
            OP_SUB:  result = bus.a_in - b_sel;
            OP_AND:  result = bus.a_in & b_sel;
            OP_OR:   result = bus.a_in | b_sel;
            OP_XOR:  result = bus.a_in ^ b_sel;
            OP_SLT:  result = {{(DSIZE-1){1'b0}}, ($signed(bus.a_in) < $signed(b_sel))};
            OP_SLL:  result = bus.a_in << b_sel[4:0];
            OP_SRL:  result = bus.a_in >> b_sel[4:0];
            default: result = '0;
        endcase
    end

    exe_stage_mul_iter #(.DSIZE(DSIZE)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a_in),
        .b       (b_sel),
        .done    (mul_done),
        .product (mul_product)
    );

    // Next state and EXE/MEM register inputs; MUL loads bubbles until the product is ready
    always_comb begin
        state_d     = state_q;
        alu_d       = alu_q;
        waddr_d     = waddr_q;
        wen_d       = wen_q;
        waddr_cap_d = waddr_cap_q;
        stall_c     = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_in == OP_MUL) begin
                    mul_start   = 1'b1;
                    stall_c     = 1'b1;
                    waddr_cap_d = bus.waddr_in;
                    wen_d       = 1'b0;
                    waddr_d     = '0;
                    state_d     = ST_BUSY;
                end else begin
                    alu_d   = result;
                    wen_d   = op_writes(bus.op_in);
                    waddr_d = op_writes(bus.op_in) ? bus.waddr_in : '0;
                end
            end
            ST_BUSY: begin
                wen_d   = 1'b0;
                waddr_d = '0;
                stall_c = !mul_done;
                if (mul_done) begin
                    alu_d   = mul_product;
                    waddr_d = waddr_cap_q;
                    wen_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and EXE/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_q       <= '0;
            waddr_q     <= '0;
            wen_q       <= 1'b0;
            waddr_cap_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_q       <= alu_d;
            waddr_q     <= waddr_d;
            wen_q       <= wen_d;
            waddr_cap_q <= waddr_cap_d;
        end
    end

    assign bus.alu_out   = alu_q;
    assign bus.waddr_out = waddr_q;
    assign bus.wen_out   = wen_q;
    // Stall is masked during reset so upstream is never held by a stage being cleared
    assign bus.stall     = stall_c & ~rst;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard testbench for exe_stage
module tb_exe_stage;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exe_stage_if #(.DSIZE(32), .ASIZE(5)) bus_if ();

    exe_stage #(.DSIZE(32), .ASIZE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  waddr;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   pop_cycle[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] src,
                                          input logic [31:0] sx);
        logic [31:0] bb;
        logic [63:0] prod;
        if (src == 2'b01)      bb = sx;
        else if (src == 2'b10) bb = {16'h0000, sx[15:0]};
        else                   bb = b;
        prod = {32'd0, a} * {32'd0, bb};
        case (op)
            6'd1:    return a + bb;
            6'd2:    return a - bb;
            6'd3:    return a & bb;
            6'd4:    return a | bb;
            6'd5:    return a ^ bb;
            6'd6:    return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            6'd7:    return a << bb[4:0];
            6'd8:    return a >> bb[4:0];
            6'd9:    return prod[31:0];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Pop and compare every committed write
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus_if.wen_out) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_wen", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq({e.tag, "_alu"}, 64'(bus_if.alu_out), 64'(e.res));
                check_eq({e.tag, "_waddr"}, 64'(bus_if.waddr_out), 64'(e.waddr));
                pop_cycle.push_back(cycle);
            end
        end
    end

    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] src, input logic [31:0] sx,
                         input logic [4:0] waddr, output int nstall);
        bit released;
        bus_if.op_in      = op;
        bus_if.a_in       = a;
        bus_if.b_in       = b;
        bus_if.src_in     = src;
        bus_if.signext_in = sx;
        bus_if.waddr_in   = waddr;
        if (op >= 6'd1 && op <= 6'd9) sb.push_back('{model(op, a, b, src, sx), waddr, tag});
        nstall   = 0;
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk);
            if (!bus_if.stall) begin
                released = 1'b1;
            end else begin
                if (nstall >= 1) check_eq({tag, "_wen_busy"}, 64'(bus_if.wen_out), 64'd0);
                nstall++;
            end
        end
        if (!released) check_eq({tag, "_timeout"}, 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus_if.op_in = 6'd0;
    endtask

    initial begin
        int ns;
        int n0;
        rst               = 1'b1;
        bus_if.op_in      = 6'd0;
        bus_if.a_in       = '0;
        bus_if.b_in       = '0;
        bus_if.src_in     = 2'b00;
        bus_if.signext_in = '0;
        bus_if.waddr_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_alu", 64'(bus_if.alu_out), 64'd0);
        check_eq("reset_wen", 64'(bus_if.wen_out), 64'd0);
        check_eq("reset_waddr", 64'(bus_if.waddr_out), 64'd0);
        check_eq("reset_stall", 64'(bus_if.stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD with immediate, observed directly, then async reset before the next edge
        bus_if.op_in      = 6'd1;
        bus_if.a_in       = 32'd5;
        bus_if.src_in     = 2'b01;
        bus_if.signext_in = 32'hFFFF_FFFD;
        bus_if.waddr_in   = 5'd3;
        @(posedge clk);
        #1;
        bus_if.op_in = 6'd9;
        check_eq("add_imm_alu", 64'(bus_if.alu_out), 64'd2);
        check_eq("add_imm_wen", 64'(bus_if.wen_out), 64'd1);
        check_eq("add_imm_waddr", 64'(bus_if.waddr_out), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_rst_alu", 64'(bus_if.alu_out), 64'd0);
        check_eq("async_rst_wen", 64'(bus_if.wen_out), 64'd0);
        check_eq("async_rst_waddr", 64'(bus_if.waddr_out), 64'd0);
        check_eq("async_rst_stall", 64'(bus_if.stall), 64'd0);
        bus_if.op_in = 6'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("slt",  6'd6, 32'hFFFF_FFFF, 32'd1,         2'b00, 32'd0,         5'd1, ns);
        do_op("sub",  6'd2, 32'd0,         32'd1,         2'b00, 32'd0,         5'd2, ns);
        do_op("srl",  6'd8, 32'h8000_0000, 32'd31,        2'b00, 32'd0,         5'd4, ns);
        do_op("and",  6'd3, 32'hF0F0_FFFF, 32'd0,         2'b10, 32'hFFFF_1234, 5'd5, ns);
        do_op("or",   6'd4, 32'h0000_0001, 32'd0,         2'b10, 32'h8000_8000, 5'd6, ns);
        do_op("xor",  6'd5, 32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 32'd0,         5'd7, ns);
        do_op("sll",  6'd7, 32'h0000_0001, 32'h0000_0023, 2'b00, 32'd0,         5'd8, ns);
        do_op("rsvd", 6'd1, 32'd10,        32'd20,        2'b11, 32'd99,        5'd10, ns);
        do_op("nop",  6'd0, 32'd3,         32'd4,         2'b00, 32'd0,         5'd11, ns);
        do_op("op63", 6'd63, 32'd3,        32'd4,         2'b00, 32'd0,         5'd12, ns);
        check_eq("bad_op_waddr", 64'(bus_if.waddr_out), 64'd0);
        check_eq("bad_op_wen", 64'(bus_if.wen_out), 64'd0);

        do_op("mul7x6", 6'd9, 32'd7, 32'd6, 2'b00, 32'd0, 5'd9, ns);
        check_eq("mul7x6_stall_cycles", 64'(ns), 64'd32);
        do_op("mulff", 6'd9, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'd0, 5'd13, ns);
        check_eq("mulff_stall_cycles", 64'(ns), 64'd32);

        n0 = pop_cycle.size() + 1;
        do_op("b2b_mul1", 6'd9, 32'd3, 32'd4, 2'b00, 32'd0, 5'd14, ns);
        do_op("b2b_mul2", 6'd9, 32'd5, 32'd5, 2'b00, 32'd0, 5'd15, ns);
        check_eq("b2b_mul2_stall_cycles", 64'(ns), 64'd32);
        do_op("b2b_add",  6'd1, 32'd1, 32'd1, 2'b00, 32'd0, 5'd16, ns);
        repeat (2) @(posedge clk);
        #1;
        if (pop_cycle.size() >= n0 + 3) begin
            check_eq("b2b_add_gap", 64'(pop_cycle[n0 + 2] - pop_cycle[n0 + 1]), 64'd1);
        end else begin
            check_eq("b2b_pop_count", 64'(pop_cycle.size()), 64'(n0 + 3));
        end

        // Reset while the multiplier is at iteration 10
        bus_if.op_in  = 6'd9;
        bus_if.a_in   = 32'd9;
        bus_if.b_in   = 32'd9;
        bus_if.src_in = 2'b00;
        bus_if.waddr_in = 5'd17;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        check_eq("mid_mul_stall_before_rst", 64'(bus_if.stall), 64'd1);
        bus_if.op_in = 6'd0;
        rst = 1'b1;
        #1;
        check_eq("mid_mul_rst_stall", 64'(bus_if.stall), 64'd0);
        check_eq("mid_mul_rst_wen", 64'(bus_if.wen_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        do_op("post_rst_add", 6'd1, 32'd10, 32'd20, 2'b00, 32'd0, 5'd18, ns);
        check_eq("post_rst_add_stall", 64'(ns), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
